path_delay_monitor: RTL and testbench

PATH_DELAY_MONITOR -- requirements
Module: path_delay_monitor

---
 rtl/path_delay_monitor.sv | 180 ++++++++++++++++++
 tb/tb_path_delay_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_monitor.sv
// path_delay_monitor
// Repeatedly launches a transition into a monitored path, samples the path
// output a programmable number of cycles later and counts trials whose
// sampled level differs from the expected settled level. A run whose error
// count reaches the programmed threshold raises trojan_flag.
//
// Trial timeline (E0 = closing edge of LAUNCH, d = capture_dly):
//   LAUNCH (1) -> WAIT (d, skipped when d == 0) -> SAMPLE (1) -> COMPARE (1)
//   -> SETTLE (SETTLE_CYC), i.e. d + 3 + SETTLE_CYC cycles per trial.
// path_in is captured at E0 + d + 1 and re-registered at the end of COMPARE
// so the possibly-metastable first stage has a full cycle to resolve. The
// mismatch decision from that re-registered value lands on the first SETTLE
// edge, which is why SETTLE_CYC must be at least 1.
// done, busy and trojan_flag are registered from the DONE state, so the done
// pulse appears the cycle after DONE is occupied.

module path_delay_monitor #(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  capture_dly,
    input  logic [15:0] num_trials,
    input  logic        polarity,
    input  logic [15:0] err_thresh,
    output logic        launch_out,
    input  logic        path_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [15:0] first_err,
    output logic        trojan_flag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        SAMPLE  = 3'd3,
        COMPARE = 3'd4,
        SETTLE  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [15:0] NO_ERR    = 16'hFFFF;

    state_t      state;

    // configuration captured when a start is accepted
    logic [7:0]  dly_q;
    logic [15:0] ntr_q;
    logic        pol_q;
    logic [15:0] thr_q;

    // shared down-counter for WAIT and SETTLE, plus the running trial index
    logic [7:0]  cnt;
    logic [15:0] trial_idx;

    // sample flop, re-register flop, and the pending-compare strobe
    logic        samp_q;
    logic        samp_sync;
    logic        cmp_pend;
    logic        mismatch;

    // Expected settled level is the launched level with the path's inversion
    assign mismatch = samp_sync != (launch_out ^ pol_q);

    // Capture path_in at the end of SAMPLE, then re-register it during COMPARE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q    <= 1'b0;
            samp_sync <= 1'b0;
        end else begin
            if (state == SAMPLE)
                samp_q <= path_in;
            if (state == COMPARE)
                samp_sync <= samp_q;
        end
    end

    // Run-control FSM with registered launch, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dly_q       <= 8'd0;
            ntr_q       <= 16'd0;
            pol_q       <= 1'b0;
            thr_q       <= 16'd0;
            cnt         <= 8'd0;
            trial_idx   <= 16'd0;
            cmp_pend    <= 1'b0;
            launch_out  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= 16'd0;
            first_err   <= NO_ERR;
            trojan_flag <= 1'b0;
        end else begin
            done     <= 1'b0;
            cmp_pend <= 1'b0;

            // apply the compare result resolved from the re-registered sample
            if (cmp_pend && mismatch) begin
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (err_count == 16'd0)
                    first_err <= trial_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        dly_q       <= capture_dly;
                        ntr_q       <= num_trials;
                        pol_q       <= polarity;
                        thr_q       <= err_thresh;
                        err_count   <= 16'd0;
                        first_err   <= NO_ERR;
                        trojan_flag <= 1'b0;
                        trial_idx   <= 16'd0;
                        if (num_trials == 16'd0) begin
                            state <= DONE;
                        end else begin
                            state <= LAUNCH;
                            busy  <= 1'b1;
                        end
                    end
                end

                LAUNCH: begin
                    // no reset of the level at run start: each run continues
                    // the alternation from wherever the previous one left it
                    launch_out <= ~launch_out;
                    cnt        <= dly_q;
                    state      <= (dly_q == 8'd0) ? SAMPLE : WAIT;
                end

                WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1)
                        state <= SAMPLE;
                end

                SAMPLE: begin
                    state <= COMPARE;
                end

                COMPARE: begin
                    cmp_pend <= 1'b1;
                    cnt      <= SETTLE_LD;
                    state    <= SETTLE;
                end

                SETTLE: begin
                    if (cnt == 8'd1) begin
                        trial_idx <= trial_idx + 16'd1;
                        state     <= ((trial_idx + 16'd1) < ntr_q) ? LAUNCH : DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    trojan_flag <= (err_count >= thr_q);
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_monitor.sv
// Bench for path_delay_monitor: a delay-line model of the monitored path
// with optional inversion and per-trial fault injection, and a trial-level
// reference model that predicts the run results and done timing.

module tb_path_delay_monitor;

    localparam int SC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  capture_dly = 8'd0;
    logic [15:0] num_trials = 16'd0;
    logic        polarity = 1'b0;
    logic [15:0] err_thresh = 16'd0;
    logic        launch_out;
    logic        path_in;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [15:0] first_err;
    logic        trojan_flag;

    path_delay_monitor #(.SETTLE_CYC(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .capture_dly (capture_dly),
        .num_trials  (num_trials),
        .polarity    (polarity),
        .err_thresh  (err_thresh),
        .launch_out  (launch_out),
        .path_in     (path_in),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .first_err   (first_err),
        .trojan_flag (trojan_flag)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // path model: launch_out delayed pd cycles, optionally inverted,
    // with an extra flip on trials selected by inj_mask
    logic [7:0]  pipe = 8'd0;
    int          pd = 3;
    logic        pinv = 1'b0;
    logic [15:0] inj_mask = 16'd0;
    int          toggles = 0;
    int          run_base = 0;
    int          trial_k;
    logic        inj;
    logic        exp_launch = 1'b0;

    always @(posedge clk) pipe <= {pipe[6:0], launch_out};
    always @(launch_out) toggles++;

    always_comb begin
        trial_k = toggles - run_base - 1;
        inj = 1'b0;
        if (trial_k >= 0 && trial_k < 16)
            inj = inj_mask[trial_k[3:0]];
        path_in = pipe[3'(pd - 1)] ^ pinv ^ inj;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Trial-level prediction: trial k launches level L; the path shows the
    // new level at the sample edge only if capture_dly >= path delay.
    task automatic model(input int d, input int n, input int dd, input logic pol,
                         input logic inv, input logic [15:0] mask, input logic [15:0] thr,
                         output logic [15:0] e, output logic [15:0] f, output logic flag);
        logic lvl, samp;
        e = 16'd0;
        f = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            lvl  = exp_launch ^ ((k % 2) == 0);
            samp = ((d >= dd) ? lvl : ~lvl) ^ inv ^ ((k < 16) ? mask[k] : 1'b0);
            if (samp != (lvl ^ pol)) begin
                if (e == 16'd0) f = 16'(k);
                if (e != 16'hFFFF) e = e + 16'd1;
            end
        end
        flag = (e >= thr);
    endtask

    task automatic scramble();
        capture_dly = 8'($urandom);
        num_trials  = 16'($urandom);
        polarity    = 1'($urandom);
        err_thresh  = 16'($urandom);
    endtask

    // one complete run with cycle-by-cycle busy/done checking
    task automatic run(input int d, input int n, input int dd, input logic pol,
                       input logic inv, input logic [15:0] mask, input logic [15:0] thr);
        int cyc, exp_c;
        logic [15:0] e, f;
        logic fl;
        pd = dd; pinv = inv; inj_mask = mask;
        repeat (10) @(negedge clk);
        capture_dly = 8'(d); num_trials = 16'(n); polarity = pol; err_thresh = thr;
        start = 1'b1;
        run_base = toggles;
        @(negedge clk);
        start = 1'b0;
        exp_c = n * (d + 3 + SC) + 2;
        cyc = 1;
        while (1) begin
            check("busy", busy, (n > 0 && cyc < exp_c));
            check("done", done, cyc == exp_c);
            if (done) break;
            if (cyc >= exp_c + 20) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
            scramble();
            @(negedge clk);
            cyc++;
        end
        model(d, n, dd, pol, inv, mask, thr, e, f, fl);
        check("err_count", err_count, e);
        check("first_err", first_err, f);
        check("trojan_flag", trojan_flag, fl);
        check("launch_toggles", toggles - run_base, n);
        exp_launch = exp_launch ^ n[0];
        check("launch_level", launch_out, exp_launch);
        repeat (3) @(negedge clk);
        check("hold_err", err_count, e);
        check("hold_first", first_err, f);
        check("hold_flag", trojan_flag, fl);
        check("done_low", done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_launch", launch_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err, 16'hFFFF);
        check("rst_flag", trojan_flag, 0);
        rst_n = 1'b1;

        // ideal path, delay 3, capture 5: all trials pass
        run(5, 10, 3, 1'b0, 1'b0, 16'h0000, 16'd1);
        check("ideal_err", err_count, 0);
        check("ideal_first", first_err, 16'hFFFF);
        check("ideal_flag", trojan_flag, 0);
        // sampled too early: every trial mismatches
        run(1, 10, 3, 1'b0, 1'b0, 16'h0000, 16'd1);
        check("early_err", err_count, 10);
        check("early_first", first_err, 0);
        check("early_flag", trojan_flag, 1);
        // inverting path with polarity 1
        run(4, 4, 2, 1'b1, 1'b1, 16'h0000, 16'd1);
        check("inv_err", err_count, 0);
        // single injected flip on trial 6
        run(5, 8, 3, 1'b0, 1'b0, 16'h0040, 16'd2);
        check("inj_err", err_count, 1);
        check("inj_first", first_err, 6);
        check("inj_flag", trojan_flag, 0);
        // zero-trial runs: flag only from a zero threshold
        run(3, 0, 3, 1'b0, 1'b0, 16'h0000, 16'd0);
        check("zero_flag_t0", trojan_flag, 1);
        run(3, 0, 3, 1'b0, 1'b0, 16'h0000, 16'd5);
        check("zero_flag_t5", trojan_flag, 0);
        // capture_dly 0 skips WAIT; path delay 1 then too slow
        run(0, 3, 1, 1'b0, 1'b0, 16'h0000, 16'd3);
        check("d0_err", err_count, 3);

        // start re-pulsed in WAIT, reset asserted in SETTLE of trial 2
        pd = 3; pinv = 1'b1; inj_mask = 16'h0000;
        repeat (10) @(negedge clk);
        capture_dly = 8'd5; num_trials = 16'd4; polarity = 1'b0; err_thresh = 16'd1;
        start = 1'b1;
        run_base = toggles;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 60; cyc++) begin
            check("abort_no_done", done, 0);
            start = (cyc == 3);
            if (cyc == 59) begin
                check("abort_err", err_count, 3);
                check("abort_first", first_err, 0);
                check("abort_busy", busy, 1);
                check("abort_toggles", toggles - run_base, 3);
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_launch", launch_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err_count, 0);
        check("arst_first", first_err, 16'hFFFF);
        check("arst_flag", trojan_flag, 0);
        exp_launch = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_done", done, 0);
        rst_n = 1'b1;
        pinv = 1'b0;
        run(5, 2, 3, 1'b0, 1'b0, 16'h0000, 16'd1);
        check("post_rst_err", err_count, 0);

        // randomized runs against the trial-level model
        for (int r = 0; r < 22; r++) begin
            run(int'($urandom_range(0, 10)), int'($urandom_range(0, 12)),
                int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom),
                16'($urandom & $urandom), 16'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
